// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if -- handshake and strobe bundle between the AES round
// controller and its environment.
//   start, key_ready, sub_flag : requests/status into the controller
//   sub_en, sr_en, mc_en, ark_en: datapath enables out of the controller
//   round_idx, busy, done, err : controller status
// modport slave  : the controller side
// modport master : the environment (key schedule, SubBytes, host) side
interface aes_round_ctrl_if;
  logic       start;
  logic       key_ready;
  logic       sub_flag;
  logic       sub_en;
  logic       sr_en;
  logic       mc_en;
  logic       ark_en;
  logic [3:0] round_idx;
  logic       busy;
  logic       done;
  logic       err;

  modport slave (
    input  start, key_ready, sub_flag,
    output sub_en, sr_en, mc_en, ark_en, round_idx, busy, done, err
  );

  modport master (
    output start, key_ready, sub_flag,
    input  sub_en, sr_en, mc_en, ark_en, round_idx, busy, done, err
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl -- sequences one AES block encryption:
// initial AddRoundKey, then NR rounds of SubBytes/ShiftRows/MixColumns/
// AddRoundKey (the last round skips MixColumns). A watchdog bounds the
// time spent waiting on the serial SubBytes unit.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : aes_round_ctrl_if.slave (start/key_ready/sub_flag in;
//          sub_en/sr_en/mc_en/ark_en/round_idx/busy/done/err out)
module aes_round_ctrl #(
  parameter int NR   = 10,
  parameter int WDOG = 15
) (
  input  logic              clk,
  input  logic              rst,
  aes_round_ctrl_if.slave   bus
);

  localparam int WW = $clog2(WDOG + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT_ARK = 3'd1,
    S_SUB      = 3'd2,
    S_SR       = 3'd3,
    S_MC       = 3'd4,
    S_ARK      = 3'd5,
    S_DONE     = 3'd6,
    S_ERR      = 3'd7
  } state_t;

  state_t          state_r, state_s;
  logic [3:0]      round_r, round_s;
  logic [WW-1:0]   wdog_r, wdog_s;

  // Output flops are loaded from the next state so each strobe is
  // glitch-free and aligned with the state it belongs to.
  logic            sub_en_r, sr_en_r, mc_en_r, ark_pend_r;
  logic            busy_r, done_r, err_r;

  // Next-state, round index and watchdog logic.
  always_comb begin
    state_s = state_r;
    round_s = round_r;
    wdog_s  = wdog_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_s = S_INIT_ARK;
          round_s = 4'd0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_INIT_ARK: begin
        if (bus.key_ready) begin
          state_s = S_SUB;
          round_s = 4'd1;
          wdog_s  = {WW{1'b0}};
        end else begin
          state_s = S_INIT_ARK;
        end
      end
      S_SUB: begin
        wdog_s = wdog_r + {{(WW-1){1'b0}}, 1'b1};
        // sub_flag has priority over a simultaneous timeout.
        if (bus.sub_flag) begin
          state_s = S_SR;
        end else if (wdog_r == WW'(WDOG - 1)) begin
          state_s = S_ERR;
          round_s = 4'd0;
        end else begin
          state_s = S_SUB;
        end
      end
      S_SR: begin
        if (round_r < 4'(NR)) begin
          state_s = S_MC;
        end else begin
          state_s = S_ARK;
        end
      end
      S_MC: begin
        state_s = S_ARK;
      end
      S_ARK: begin
        if (!bus.key_ready) begin
          state_s = S_ARK;
        end else if (round_r == 4'(NR)) begin
          state_s = S_DONE;
        end else begin
          state_s = S_SUB;
          round_s = round_r + 4'd1;
          wdog_s  = {WW{1'b0}};
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      S_ERR: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
        round_s = 4'd0;
        wdog_s  = {WW{1'b0}};
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      round_r    <= 4'd0;
      wdog_r     <= {WW{1'b0}};
      sub_en_r   <= 1'b0;
      sr_en_r    <= 1'b0;
      mc_en_r    <= 1'b0;
      ark_pend_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      round_r    <= round_s;
      wdog_r     <= wdog_s;
      sub_en_r   <= (state_s == S_SUB);
      sr_en_r    <= (state_s == S_SR);
      mc_en_r    <= (state_s == S_MC);
      ark_pend_r <= (state_s == S_INIT_ARK) || (state_s == S_ARK);
      busy_r     <= (state_s == S_INIT_ARK) || (state_s == S_SUB) ||
                    (state_s == S_SR) || (state_s == S_MC) ||
                    (state_s == S_ARK);
      done_r     <= (state_s == S_DONE);
      err_r      <= (state_s == S_ERR);
    end
  end

  // ark_en must drop in the very cycle key_ready is low, so it is the
  // registered "in an ARK state" flag qualified by the live key_ready.
  assign bus.ark_en    = ark_pend_r & bus.key_ready;
  assign bus.sub_en    = sub_en_r;
  assign bus.sr_en     = sr_en_r;
  assign bus.mc_en     = mc_en_r;
  assign bus.round_idx = round_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl -- directed bench for aes_round_ctrl with a small
// SubBytes responder model and hand-computed cycle numbers.
module tb_aes_round_ctrl;
  localparam int NR   = 10;
  localparam int WDOG = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_round_ctrl_if bus();

  aes_round_ctrl #(.NR(NR), .WDOG(WDOG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_mis = 0;

  int cyc, done_cyc, err_cyc, first_ark, sr_first, done_round;
  int ark_n, mc_n, sr_n, excl_bad, range_bad;
  bit rst_hit;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sub_en"}, int'(bus.sub_en), 0);
    chk({tag, "_sr_en"},  int'(bus.sr_en),  0);
    chk({tag, "_mc_en"},  int'(bus.mc_en),  0);
    chk({tag, "_ark_en"}, int'(bus.ark_en), 0);
    chk({tag, "_busy"},   int'(bus.busy),   0);
    chk({tag, "_done"},   int'(bus.done),   0);
    chk({tag, "_err"},    int'(bus.err),    0);
    chk({tag, "_round"},  int'(bus.round_idx), 0);
  endtask

  // Start one block at edge 0 and run until done/err/reset or budget.
  // flag_at: SUB cycle in which sub_flag is returned (0 = never).
  task automatic run_block(input int flag_at, input bit key_stall,
                           input bit ignore_in, input bit rst_mc6,
                           input int budget);
    int  sub_cnt;
    int  stall_left;
    int  strobes;
    bit  prev_mc;
    bit  stop;
    sub_cnt = 0; stall_left = 0; prev_mc = 1'b0; stop = 1'b0;
    done_cyc = -1; err_cyc = -1; first_ark = -1; sr_first = -1;
    done_round = -1; ark_n = 0; mc_n = 0; sr_n = 0;
    excl_bad = 0; range_bad = 0; rst_hit = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.key_ready = 1'b1; bus.sub_flag = 1'b0;
    step();
    bus.start = 1'b0;
    cyc = 1;
    while (!stop && cyc <= budget) begin
      if (key_stall && (cyc == 1 || (prev_mc && bus.round_idx == 4'd5)))
        stall_left = 3;
      bus.key_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (bus.sub_en) begin
        sub_cnt++;
        bus.sub_flag = (flag_at != 0) && (sub_cnt == flag_at);
      end else begin
        sub_cnt = 0;
        bus.sub_flag = ignore_in && bus.mc_en;
      end
      bus.start = ignore_in && (cyc >= 10) && (cyc <= 12);
      if (rst_mc6 && bus.mc_en && bus.round_idx == 4'd6) begin
        rst = 1'b1;
        rst_hit = 1'b1;
      end
      #1;
      if (!bus.key_ready) chk("ark_wait", int'(bus.ark_en), 0);
      if (bus.ark_en) begin
        ark_n++;
        if (first_ark < 0) first_ark = cyc;
      end
      mc_n += int'(bus.mc_en);
      sr_n += int'(bus.sr_en);
      if (bus.sr_en && sr_first < 0) sr_first = cyc;
      strobes = int'(bus.sr_en) + int'(bus.mc_en) + int'(bus.ark_en) +
                int'(bus.done) + int'(bus.err);
      if (strobes > 1) excl_bad++;
      if (bus.round_idx > 4'(NR)) range_bad++;
      if (bus.done) begin
        done_cyc = cyc;
        done_round = int'(bus.round_idx);
      end
      if (bus.err) err_cyc = cyc;
      prev_mc = bus.mc_en;
      stop = bus.done || bus.err || rst_hit;
      if (!stop) begin
        step();
        cyc++;
      end
    end
    bus.start = 1'b0; bus.sub_flag = 1'b0; bus.key_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b1; bus.key_ready = 1'b1; bus.sub_flag = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    step();
    chk("start_in_rst_busy", int'(bus.busy), 0);

    // nominal
    run_block(5, 1'b0, 1'b0, 1'b0, 200);
    chk("nom_first_ark", first_ark, 1);
    chk("nom_done_cyc",  done_cyc, 81);
    chk("nom_done_round", done_round, NR);
    chk("nom_ark_n", ark_n, 11);
    chk("nom_mc_n",  mc_n, 9);
    chk("nom_sr_n",  sr_n, 10);
    chk("nom_err",   err_cyc, -1);
    chk("nom_excl",  excl_bad, 0);
    chk("nom_range", range_bad, 0);
    step();
    chk("nom_idle_busy", int'(bus.busy), 0);

    // key stall at INIT_ARK and round-5 ARK
    run_block(5, 1'b1, 1'b0, 1'b0, 200);
    chk("stall_first_ark", first_ark, 4);
    chk("stall_done_cyc",  done_cyc, 87);
    chk("stall_ark_n", ark_n, 11);
    chk("stall_excl",  excl_bad, 0);
    step();

    // watchdog timeout
    run_block(0, 1'b0, 1'b0, 1'b0, 200);
    chk("to_err_cyc", err_cyc, 17);
    chk("to_done",    done_cyc, -1);
    chk("to_err_round", int'(bus.round_idx), 0);
    chk("to_err_sub_en", int'(bus.sub_en), 0);
    step();
    chk("to_idle_busy",  int'(bus.busy), 0);
    chk("to_idle_round", int'(bus.round_idx), 0);
    chk("to_idle_err",   int'(bus.err), 0);

    // sub_flag on the same cycle as the timeout
    run_block(15, 1'b0, 1'b0, 1'b0, 300);
    chk("tie_err",      err_cyc, -1);
    chk("tie_sr_first", sr_first, 17);
    chk("tie_done_cyc", done_cyc, 181);
    step();

    // start while busy, sub_flag in MC
    run_block(5, 1'b0, 1'b1, 1'b0, 200);
    chk("ign_done_cyc", done_cyc, 81);
    chk("ign_ark_n", ark_n, 11);
    chk("ign_mc_n",  mc_n, 9);
    chk("ign_sr_n",  sr_n, 10);
    step();

    // reset in round-6 MC, then a fresh block
    run_block(5, 1'b0, 1'b0, 1'b1, 200);
    chk("mrst_hit", int'(rst_hit), 1);
    step();
    rst = 1'b0;
    chk_all_zero("mrst");
    run_block(5, 1'b0, 1'b0, 1'b0, 200);
    chk("mrst_done_cyc", done_cyc, 81);
    chk("mrst_first_ark", first_ark, 1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
